gb_line_buffer: RTL and testbench

//  Parametrised successor to the single Gameboy capture FIFO. Captures the Gameboy LCD stream
//  (GB_PIXEL_CLOCK/HSYNC/VSYNC/DATA) into a bank-rotating line buffer inside the SYSTEM_CLOCK domain.

---
 rtl/gb_video_pkg.sv | 23 ++
 rtl/gb_sync_edge.sv | 35 +++
 rtl/gb_line_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_gb_line_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared Gameboy video constants and FSM encodings
// for the LCD capture and line replay path.
package gb_video_pkg;

  localparam int LINE_PIXELS_GB = 160;
  localparam int LINES_GB       = 144;

  localparam logic [1:0] SHADE_WHITE = 2'd0;
  localparam logic [1:0] SHADE_LIGHT = 2'd1;
  localparam logic [1:0] SHADE_DARK  = 2'd2;
  localparam logic [1:0] SHADE_BLACK = 2'd3;

  typedef enum logic {
    W_IDLE,
    W_LINE
  } wr_state_e;

  typedef enum logic {
    R_WAIT,
    R_ACTIVE
  } rd_state_e;

endpackage

// File: rtl/gb_sync_edge.sv
// Two-flop synchroniser for async GB pins with
// rise/fall pulses taken from the synced copy.
module gb_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] s3_q;

  // synchroniser chain plus one delay stage for edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/gb_line_buffer.sv
// Bank-rotating GB line buffer: captures LCD lines
// and replays them scaled against the output raster.
module gb_line_buffer
  import gb_video_pkg::*;
#(
  parameter int PIXEL_W     = 2,
  parameter int LINE_PIXELS = LINE_PIXELS_GB,
  parameter int BANKS       = 4,
  parameter int H_SCALE     = 2,
  parameter int V_SCALE     = 2,
  parameter int H_START     = 80,
  parameter int CNT_W       = 9
) (
  input  logic               SYSTEM_CLOCK,
  input  logic               RESET,
  input  logic               GB_PIXEL_CLOCK,
  input  logic               GB_HSYNC,
  input  logic               GB_VSYNC,
  input  logic [PIXEL_W-1:0] GB_DATA,
  input  logic [CNT_W-1:0]   H_COUNTER,
  input  logic [CNT_W-1:0]   V_COUNTER,
  output logic [PIXEL_W-1:0] PIXEL_OUT,
  output logic               PIXEL_VALID,
  output logic               FRAME_LOCKED,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  localparam int SH = $clog2(H_SCALE);
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int CW = $clog2(BANKS + 1);
  localparam int XW = $clog2(LINE_PIXELS + 1);
  localparam int AW = $clog2(BANKS * LINE_PIXELS);
  localparam int VW = 3;
  localparam int HE = H_START + LINE_PIXELS * H_SCALE;

  localparam logic [CNT_W-1:0] H_BEG = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_END = CNT_W'(HE);
  localparam logic [XW-1:0]    X_MAX = XW'(LINE_PIXELS);

  function automatic logic [BW-1:0] bank_inc(
    input logic [BW-1:0] b
  );
    if (b == BW'(BANKS - 1)) return '0;
    return b + 1'b1;
  endfunction

  logic pix_fall, hs_rise, vs_rise;
  logic [PIXEL_W-1:0] dat_s;
  logic unused_pix_q, unused_pix_rise;
  logic unused_hs_q, unused_hs_fall;
  logic unused_vs_q, unused_vs_fall;
  logic [PIXEL_W-1:0] unused_dat_rise, unused_dat_fall;

  gb_sync_edge #(.W(1)) u_pix (
    .clk_i(SYSTEM_CLOCK), .rst_i(RESET),
    .d_i(GB_PIXEL_CLOCK), .q_o(unused_pix_q),
    .rise_o(unused_pix_rise), .fall_o(pix_fall)
  );
  gb_sync_edge #(.W(1)) u_hs (
    .clk_i(SYSTEM_CLOCK), .rst_i(RESET),
    .d_i(GB_HSYNC), .q_o(unused_hs_q),
    .rise_o(hs_rise), .fall_o(unused_hs_fall)
  );
  gb_sync_edge #(.W(1)) u_vs (
    .clk_i(SYSTEM_CLOCK), .rst_i(RESET),
    .d_i(GB_VSYNC), .q_o(unused_vs_q),
    .rise_o(vs_rise), .fall_o(unused_vs_fall)
  );
  gb_sync_edge #(.W(PIXEL_W)) u_dat (
    .clk_i(SYSTEM_CLOCK), .rst_i(RESET),
    .d_i(GB_DATA), .q_o(dat_s),
    .rise_o(unused_dat_rise), .fall_o(unused_dat_fall)
  );

  wr_state_e wst_q, wst_d;
  logic [XW-1:0] wcol_q, wcol_d;
  logic [BW-1:0] wbank_q, wbank_d;
  logic drop_q, drop_d;
  logic lock_q, lock_d;
  logic ovf_q, ovf_d;

  rd_state_e rst_q, rst_d;
  logic [BW-1:0] rbank_q, rbank_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vrep_q, vrep_d;
  logic unf_q, unf_d;
  logic val_q;
  logic [PIXEL_W-1:0] rd_q;

  logic [PIXEL_W-1:0] mem [BANKS*LINE_PIXELS];

  logic line_on, pix_ok, bank_free, we;
  logic full_line, commit, ovf_evt;
  logic in_win, at_start, have, take, skip;
  logic win_end, last_rep, free, active;
  logic [BW:0] sum;
  logic [BW-1:0] newest, rsel;
  logic [CNT_W-1:0] hoff, col;
  logic [AW-1:0] waddr, raddr;

  // write-side qualifiers: a line whose bank is
  // still held by the reader is marked dropped
  always_comb begin
    line_on   = wst_q == W_LINE;
    pix_ok    = line_on && pix_fall && wcol_q < X_MAX;
    bank_free = cnt_q < CW'(BANKS);
    we        = pix_ok && bank_free;
    full_line = wcol_q == X_MAX;
    commit    = line_on && hs_rise && !vs_rise
              && full_line && !drop_q;
    ovf_evt   = line_on && hs_rise && !vs_rise
              && full_line && drop_q;
    waddr     = AW'(wbank_q) * AW'(LINE_PIXELS)
              + AW'(wcol_q);
  end

  // write FSM next state; vsync overrides everything
  always_comb begin
    wst_d   = wst_q;
    wcol_d  = wcol_q;
    wbank_d = wbank_q;
    drop_d  = drop_q;
    lock_d  = lock_q;
    ovf_d   = ovf_q;
    unique case (wst_q)
      W_IDLE: ;
      W_LINE: begin
        if (hs_rise) begin
          wcol_d = '0;
          drop_d = 1'b0;
          if (commit) begin
            wbank_d = bank_inc(wbank_q);
            lock_d  = 1'b1;
          end
          if (ovf_evt) ovf_d = 1'b1;
        end else if (pix_ok) begin
          wcol_d = wcol_q + 1'b1;
          if (!bank_free) drop_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (vs_rise) begin
      wst_d  = W_LINE;
      wcol_d = '0;
      drop_d = 1'b0;
      lock_d = 1'b0;
    end
  end

  // read-side qualifiers and memory read address
  always_comb begin
    in_win   = H_COUNTER >= H_BEG && H_COUNTER < H_END;
    at_start = rst_q == R_WAIT && H_COUNTER == H_BEG;
    have     = cnt_q != '0;
    take     = at_start && have;
    skip     = take && V_COUNTER == '0;
    win_end  = rst_q == R_ACTIVE && !in_win;
    last_rep = vrep_q == VW'(V_SCALE - 1);
    free     = win_end && last_rep;
    active   = take || (rst_q == R_ACTIVE && in_win);
    sum      = {1'b0, rbank_q} + (BW+1)'(cnt_q)
             - (BW+1)'(1);
    if (sum >= (BW+1)'(BANKS))
      sum = sum - (BW+1)'(BANKS);
    newest   = sum[BW-1:0];
    rsel     = skip ? newest : rbank_q;
    hoff     = H_COUNTER - H_BEG;
    col      = hoff >> SH;
    raddr    = '0;
    if (active)
      raddr = AW'(rsel) * AW'(LINE_PIXELS) + AW'(col);
  end

  // read FSM next state plus bank ownership count
  always_comb begin
    rst_d   = rst_q;
    vrep_d  = vrep_q;
    unf_d   = unf_q;
    rbank_d = rbank_q;
    cnt_d   = cnt_q + CW'(commit) - CW'(free);
    unique case (rst_q)
      R_WAIT: begin
        if (at_start) begin
          if (have) rst_d = R_ACTIVE;
          else      unf_d = 1'b1;
        end
      end
      R_ACTIVE: begin
        if (!in_win) begin
          rst_d  = R_WAIT;
          vrep_d = last_rep ? '0 : vrep_q + 1'b1;
          if (free) rbank_d = bank_inc(rbank_q);
        end
      end
      default: ;
    endcase
    if (skip) begin
      vrep_d  = '0;
      rbank_d = newest;
      cnt_d   = CW'(1) + CW'(commit);
    end
  end

  // state registers for both FSMs and sticky flags
  always_ff @(posedge SYSTEM_CLOCK) begin
    if (RESET) begin
      wst_q   <= W_IDLE;
      wcol_q  <= '0;
      wbank_q <= '0;
      drop_q  <= 1'b0;
      lock_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rst_q   <= R_WAIT;
      rbank_q <= '0;
      cnt_q   <= '0;
      vrep_q  <= '0;
      unf_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      wst_q   <= wst_d;
      wcol_q  <= wcol_d;
      wbank_q <= wbank_d;
      drop_q  <= drop_d;
      lock_q  <= lock_d;
      ovf_q   <= ovf_d;
      rst_q   <= rst_d;
      rbank_q <= rbank_d;
      cnt_q   <= cnt_d;
      vrep_q  <= vrep_d;
      unf_q   <= unf_d;
      val_q   <= active;
    end
  end

  // simple dual-port line RAM with registered read
  always_ff @(posedge SYSTEM_CLOCK) begin
    if (we) mem[waddr] <= dat_s;
    rd_q <= mem[raddr];
  end

  assign PIXEL_OUT    = val_q ? rd_q : '0;
  assign PIXEL_VALID  = val_q;
  assign FRAME_LOCKED = lock_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_gb_line_buffer.sv
// Self-checking bench for gb_line_buffer using a
// queue-of-lines reference model of capture/replay.
module tb_gb_line_buffer;

  localparam int PW   = 2;
  localparam int LP   = 160;
  localparam int NB   = 4;
  localparam int HS   = 2;
  localparam int VS   = 2;
  localparam int HST  = 80;
  localparam int CNW  = 9;
  localparam int HEND = HST + LP * HS;
  localparam int HMAX = 450;

  logic clk = 1'b0;
  logic RESET;
  logic GB_PIXEL_CLOCK, GB_HSYNC, GB_VSYNC;
  logic [PW-1:0] GB_DATA;
  logic [CNW-1:0] H_COUNTER, V_COUNTER;
  logic [PW-1:0] PIXEL_OUT;
  logic PIXEL_VALID, FRAME_LOCKED, OVERFLOW, UNDERFLOW;

  gb_line_buffer #(
    .PIXEL_W(PW), .LINE_PIXELS(LP), .BANKS(NB),
    .H_SCALE(HS), .V_SCALE(VS), .H_START(HST),
    .CNT_W(CNW)
  ) dut (
    .SYSTEM_CLOCK(clk), .RESET(RESET),
    .GB_PIXEL_CLOCK(GB_PIXEL_CLOCK),
    .GB_HSYNC(GB_HSYNC), .GB_VSYNC(GB_VSYNC),
    .GB_DATA(GB_DATA),
    .H_COUNTER(H_COUNTER), .V_COUNTER(V_COUNTER),
    .PIXEL_OUT(PIXEL_OUT), .PIXEL_VALID(PIXEL_VALID),
    .FRAME_LOCKED(FRAME_LOCKED), .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 clk = ~clk;

  typedef logic [PW-1:0] line_t [LP];

  line_t m_q[$];
  int m_vrep;
  bit m_ovf, m_unf, m_lock;

  logic obs_v [HMAX];
  logic [PW-1:0] obs_o [HMAX];

  int checks = 0;
  int passed = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    GB_PIXEL_CLOCK = 1'b0;
    GB_HSYNC = 1'b0;
    GB_VSYNC = 1'b0;
    GB_DATA = '0;
    H_COUNTER = '0;
    V_COUNTER = '0;
    tick(3);
    RESET = 1'b0;
    m_q.delete();
    m_vrep = 0;
    m_ovf = 0;
    m_unf = 0;
    m_lock = 0;
    tick(2);
  endtask

  task automatic gb_pix(input logic [PW-1:0] v);
    GB_DATA = v;
    GB_PIXEL_CLOCK = 1'b1;
    tick(3);
    GB_PIXEL_CLOCK = 1'b0;
    tick(3);
  endtask

  task automatic gb_vsync();
    GB_VSYNC = 1'b1;
    tick(3);
    GB_VSYNC = 1'b0;
    tick(4);
    m_lock = 0;
  endtask

  // n pixels of l then hsync; model commits full lines
  task automatic gb_send(input line_t l, input int n);
    for (int i = 0; i < n; i++) gb_pix(l[i]);
    GB_HSYNC = 1'b1;
    tick(3);
    GB_HSYNC = 1'b0;
    tick(4);
    if (n == LP) begin
      if (m_q.size() < NB) begin
        m_q.push_back(l);
        m_lock = 1;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LP; i++)
      l[i] = PW'($urandom_range(0, 3));
    return l;
  endfunction

  // one output raster line; compares against model
  task automatic raster(input int v, output int errs,
                        output int nval,
                        output string first);
    line_t cur;
    bit have;
    logic ev;
    logic [PW-1:0] eo;
    int h;
    errs = 0;
    nval = 0;
    first = "none";
    if (v == 0 && m_q.size() > 0) begin
      while (m_q.size() > 1) void'(m_q.pop_front());
      m_vrep = 0;
    end
    have = m_q.size() > 0;
    if (have) cur = m_q[0];
    else m_unf = 1;
    V_COUNTER = CNW'(v);
    for (int i = 0; i <= HMAX; i++) begin
      @(negedge clk);
      if (i > 0) begin
        h = i - 1;
        obs_v[h] = PIXEL_VALID;
        obs_o[h] = PIXEL_OUT;
        ev = have && h >= HST && h < HEND;
        eo = ev ? cur[(h - HST) / HS] : '0;
        if (PIXEL_VALID === 1'b1) nval++;
        if (PIXEL_VALID !== ev || PIXEL_OUT !== eo) begin
          if (errs == 0)
            first = $sformatf(
              "h=%0d valid=%0b/%0b out=%0d/%0d",
              h, PIXEL_VALID, ev, PIXEL_OUT, eo);
          errs++;
        end
      end
      if (i < HMAX) H_COUNTER = CNW'(i);
    end
    H_COUNTER = '0;
    tick(2);
    if (have) begin
      m_vrep++;
      if (m_vrep == VS) begin
        void'(m_q.pop_front());
        m_vrep = 0;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(1);
    do_reset();
    checks++;
    if (PIXEL_VALID !== 1'b0) begin
      $display("FAIL reset_valid: got %0b want 0",
               PIXEL_VALID);
    end else passed++;
    checks++;
    if (PIXEL_OUT !== '0) begin
      $display("FAIL reset_out: got %0d want 0",
               PIXEL_OUT);
    end else passed++;
    checks++;
    if (FRAME_LOCKED !== 1'b0) begin
      $display("FAIL reset_lock: got %0b want 0",
               FRAME_LOCKED);
    end else passed++;
    checks++;
    if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin
      $display("FAIL reset_flags: got %b want 00",
               {OVERFLOW, UNDERFLOW});
    end else passed++;
  endtask

  task automatic test_full_line();
    line_t l;
    int e, nv;
    string f;
    do_reset();
    for (int i = 0; i < LP; i++) l[i] = 2'd2;
    gb_vsync();
    gb_send(l, LP);
    checks++;
    if (FRAME_LOCKED !== 1'b1) begin
      $display("FAIL full_lock: got %0b want 1",
               FRAME_LOCKED);
    end else passed++;
    for (int v = 0; v < VS; v++) begin
      raster(v, e, nv, f);
      checks++;
      if (e !== 0) begin
        $display("FAIL full_raster v%0d: %0d bad, %s",
                 v, e, f);
      end else passed++;
      checks++;
      if (nv !== LP * HS) begin
        $display("FAIL full_count v%0d: got %0d want %0d",
                 v, nv, LP * HS);
      end else passed++;
    end
    checks++;
    if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin
      $display("FAIL full_flags: got %b want 00",
               {OVERFLOW, UNDERFLOW});
    end else passed++;
  endtask

  task automatic test_short_line();
    do_reset();
    gb_vsync();
    gb_send(rand_line(), 100);
    checks++;
    if (FRAME_LOCKED !== 1'b0) begin
      $display("FAIL short_lock: got %0b want 0",
               FRAME_LOCKED);
    end else passed++;
    checks++;
    if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin
      $display("FAIL short_flags: got %b want 00",
               {OVERFLOW, UNDERFLOW});
    end else passed++;
  endtask

  task automatic test_overflow();
    int e, nv;
    string f;
    do_reset();
    gb_vsync();
    for (int i = 0; i < NB; i++) gb_send(rand_line(), LP);
    checks++;
    if (OVERFLOW !== 1'b0 || FRAME_LOCKED !== 1'b1) begin
      $display("FAIL ovf_four: ovf=%0b lock=%0b want 0 1",
               OVERFLOW, FRAME_LOCKED);
    end else passed++;
    gb_send(rand_line(), LP);
    checks++;
    if (OVERFLOW !== m_ovf) begin
      $display("FAIL ovf_fifth: got %0b want %0b",
               OVERFLOW, m_ovf);
    end else passed++;
    for (int v = 1; v <= NB * VS; v++) begin
      raster(v, e, nv, f);
      checks++;
      if (e !== 0) begin
        $display("FAIL ovf_raster v%0d: %0d bad, %s",
                 v, e, f);
      end else passed++;
    end
    checks++;
    if ({OVERFLOW, UNDERFLOW} !== {m_ovf, m_unf}) begin
      $display("FAIL ovf_sticky: got %b want %b",
               {OVERFLOW, UNDERFLOW}, {m_ovf, m_unf});
    end else passed++;
  endtask

  task automatic test_underflow();
    int e, nv;
    string f;
    do_reset();
    raster(3, e, nv, f);
    checks++;
    if (e !== 0 || nv !== 0) begin
      $display("FAIL unf_raster: %0d bad %0d valid, %s",
               e, nv, f);
    end else passed++;
    checks++;
    if (UNDERFLOW !== 1'b1) begin
      $display("FAIL unf_flag: got %0b want 1",
               UNDERFLOW);
    end else passed++;
  endtask

  task automatic test_ramp();
    line_t l;
    int e, nv, bad, h;
    string f;
    do_reset();
    for (int i = 0; i < LP; i++) l[i] = PW'(i % 4);
    gb_vsync();
    gb_send(l, LP);
    raster(0, e, nv, f);
    checks++;
    if (e !== 0) begin
      $display("FAIL ramp_raster: %0d bad, %s", e, f);
    end else passed++;
    bad = 0;
    f = "none";
    for (int k = 0; k < LP; k++) begin
      h = HST + 2 * k + 1;
      if (obs_v[h] !== 1'b1 || obs_o[h] !== PW'(k % 4)) begin
        if (bad == 0)
          f = $sformatf("k=%0d out=%0d want %0d",
                        k, obs_o[h], k % 4);
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      $display("FAIL ramp_odd: %0d bad, %s", bad, f);
    end else passed++;
  endtask

  task automatic test_realign();
    line_t l [3];
    int e, nv;
    string f;
    do_reset();
    gb_vsync();
    for (int i = 0; i < 3; i++) begin
      l[i] = rand_line();
      gb_send(l[i], LP);
    end
    for (int v = 0; v < 3; v++) begin
      raster(v, e, nv, f);
      checks++;
      if (e !== 0) begin
        $display("FAIL realign v%0d: %0d bad, %s",
                 v, e, f);
      end else passed++;
    end
    checks++;
    if (UNDERFLOW !== m_unf) begin
      $display("FAIL realign_unf: got %0b want %0b",
               UNDERFLOW, m_unf);
    end else passed++;
  endtask

  task automatic test_reset_midline();
    line_t l;
    int e, nv;
    string f;
    do_reset();
    gb_vsync();
    gb_send(rand_line(), LP);
    l = rand_line();
    for (int i = 0; i < 50; i++) gb_pix(l[i]);
    RESET = 1'b1;
    tick(1);
    checks++;
    if ({PIXEL_VALID, FRAME_LOCKED, OVERFLOW,
         UNDERFLOW, PIXEL_OUT} !== '0) begin
      $display("FAIL mid_reset: v%0b l%0b o%0b u%0b p%0d",
               PIXEL_VALID, FRAME_LOCKED, OVERFLOW,
               UNDERFLOW, PIXEL_OUT);
    end else passed++;
    do_reset();
    gb_vsync();
    gb_send(rand_line(), LP);
    checks++;
    if (FRAME_LOCKED !== 1'b1) begin
      $display("FAIL mid_lock: got %0b want 1",
               FRAME_LOCKED);
    end else passed++;
    for (int v = 0; v < VS; v++) begin
      raster(v, e, nv, f);
      checks++;
      if (e !== 0) begin
        $display("FAIL mid_raster v%0d: %0d bad, %s",
                 v, e, f);
      end else passed++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    GB_PIXEL_CLOCK = 1'b0;
    GB_HSYNC = 1'b0;
    GB_VSYNC = 1'b0;
    GB_DATA = '0;
    H_COUNTER = '0;
    V_COUNTER = '0;
    test_reset();
    test_full_line();
    test_short_line();
    test_overflow();
    test_underflow();
    test_ramp();
    test_realign();
    test_reset_midline();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
